// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: Z80 data/control port decode into VRAM, CRAM and VDP register writes plus VRAM read-ahead.
// Optional build macro VDP_GG_CRAM_EN selects the Game Gear 12-bit two-byte CRAM write path (SMS 6-bit otherwise).
module vdp_cpu_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_port,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic [7:0]  status_in,
    output logic        status_clr,
    output logic [13:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_wdata,
    input  logic [7:0]  vram_rdata,
    output logic        cram_we,
    output logic [4:0]  cram_addr,
`ifdef VDP_GG_CRAM_EN
    output logic [11:0] cram_wdata,
`else
    output logic [5:0]  cram_wdata,
`endif
    output logic        reg_we,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

    state_t      state_q;
    logic [13:0] addr_q, addr_d, acc_addr;
    logic [1:0]  code_q;
    logic        flag_q, flag_d;
    logic [7:0]  latch_q;
    logic [7:0]  buf_q;
    logic        accept, stb, ctl_wr, ctl_rd, dat_wr, dat_rd, first, second, fetch;
`ifdef VDP_GG_CRAM_EN
    logic [7:0]  gg_q;
`endif

    // Strobe decode and next address/flag; strobes during a fetch are dropped
    always_comb begin
        accept   = (state_q == IDLE);
        stb      = accept && (cpu_wr || cpu_rd);
        ctl_wr   = accept && cpu_wr && cpu_port;
        ctl_rd   = accept && cpu_rd && cpu_port;
        dat_wr   = accept && cpu_wr && !cpu_port;
        dat_rd   = accept && cpu_rd && !cpu_port;
        first    = ctl_wr && !flag_q;
        second   = ctl_wr && flag_q;
        acc_addr = second ? {cpu_din[5:0], addr_q[7:0]} : addr_q;
        fetch    = dat_rd || (second && cpu_din[7:6] == 2'b00);
        addr_d   = (fetch || dat_wr) ? acc_addr + 14'd1 :
                   second            ? acc_addr :
                   first             ? {addr_q[13:8], cpu_din} : addr_q;
        flag_d   = stb ? first : flag_q;
    end

    // Address, access code, byte-pair flag and first-byte latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            code_q  <= '0;
            flag_q  <= 1'b0;
            latch_q <= '0;
        end else begin
            addr_q <= addr_d;
            flag_q <= flag_d;
            if (first)
                latch_q <= cpu_din;
            if (second)
                code_q <= cpu_din[7:6];
        end
    end

    // Write side: one-cycle VRAM, CRAM and register write pulses; vram_addr holds between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
            cram_we    <= 1'b0;
            cram_addr  <= '0;
            cram_wdata <= '0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_data   <= '0;
`ifdef VDP_GG_CRAM_EN
            gg_q       <= '0;
`endif
        end else begin
            vram_we <= 1'b0;
            cram_we <= 1'b0;
            reg_we  <= 1'b0;
            if (second && cpu_din[7:6] == 2'b10) begin
                reg_we   <= 1'b1;
                reg_addr <= cpu_din[3:0];
                reg_data <= latch_q;
            end
            if (dat_wr && code_q == 2'b11) begin
`ifdef VDP_GG_CRAM_EN
                if (!addr_q[0])
                    gg_q <= cpu_din;
                else begin
                    cram_we    <= 1'b1;
                    cram_addr  <= addr_q[5:1];
                    cram_wdata <= {cpu_din[3:0], gg_q};
                end
`else
                cram_we    <= 1'b1;
                cram_addr  <= addr_q[4:0];
                cram_wdata <= cpu_din[5:0];
`endif
            end
            if (dat_wr && code_q != 2'b11) begin
                vram_we    <= 1'b1;
                vram_addr  <= addr_q;
                vram_wdata <= cpu_din;
            end
            if (fetch)
                vram_addr <= acc_addr;
        end
    end

    // Read side: read-ahead FSM, read buffer, CPU read data and status clear pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            buf_q      <= '0;
            cpu_dout   <= '0;
            status_clr <= 1'b0;
        end else begin
            status_clr <= ctl_rd;
            if (dat_rd)
                cpu_dout <= buf_q;
            if (ctl_rd)
                cpu_dout <= status_in;
            if (dat_wr)
                buf_q <= cpu_din;
            case (state_q)
                IDLE: begin
                    state_q <= fetch ? FETCH : IDLE;
                    busy    <= fetch;
                end
                FETCH: begin
                    state_q <= CAPTURE;
                    busy    <= 1'b1;
                end
                default: begin
                    buf_q   <= vram_rdata;
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb_vdp_cpu_port: table-driven directed bench for vdp_cpu_port with a synchronous-read VRAM model.
module tb_vdp_cpu_port;

    localparam int CW = 0, CR = 1, DW = 2, DR = 3, NV = 26;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_port = 1'b0;
    logic [7:0]  cpu_din = '0, status_in = '0, cpu_dout;
    logic        status_clr, vram_we, cram_we, reg_we, busy;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata, reg_data;
    logic [4:0]  cram_addr;
    logic [3:0]  reg_addr;
`ifdef VDP_GG_CRAM_EN
    logic [11:0] cram_wdata;
`else
    logic [5:0]  cram_wdata;
`endif

    logic [7:0]  mem [16384];
    int          compared = 0, mismatched = 0;

    typedef struct {
        int          kind;
        logic [7:0]  din, st;
        logic [13:0] vaddr;
        logic        vwe, rwe, cwe, sclr, bsy, cd;
        logic [7:0]  vdata, rdata, dout;
        logic [3:0]  raddr;
        logic [4:0]  caddr;
        logic [11:0] cdata;
    } vec_t;

    vec_t v [NV];

    vdp_cpu_port dut (
        .clk(clk), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_port(cpu_port),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .status_in(status_in), .status_clr(status_clr),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_we)
            mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    always @(posedge clk)
        if (rst_n && (cpu_wr || cpu_rd) && busy) begin
            mismatched++;
            $display("FAIL bus_contract: strobe while busy at %0t", $time);
        end

    function automatic vec_t mk(input int kind, input logic [7:0] din, input logic [13:0] vaddr);
        vec_t r;
        r = '{kind: kind, din: din, st: 8'h00, vaddr: vaddr, vwe: 1'b0, rwe: 1'b0, cwe: 1'b0,
              sclr: 1'b0, bsy: 1'b0, cd: 1'b0, vdata: 8'h00, rdata: 8'h00, dout: 8'h00,
              raddr: 4'h0, caddr: 5'h00, cdata: 12'h000};
        r.bsy = (kind == DR);
        r.cd  = (kind == DR) || (kind == CR);
        r.sclr = (kind == CR);
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s [%0d]: got %0h, want %0h", nm, i, act, exp);
        end
    endtask

    task automatic strobe(input int kind, input logic [7:0] din);
        @(negedge clk);
        cpu_wr   = (kind == CW) || (kind == DW);
        cpu_rd   = (kind == CR) || (kind == DR);
        cpu_port = (kind == CW) || (kind == CR);
        cpu_din  = din;
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
        mem[14'h3F02] = 8'h5C; mem[14'h3F03] = 8'h6D;
        mem[14'h3FFF] = 8'h11; mem[14'h0000] = 8'h22; mem[14'h0001] = 8'h33;
        mem[14'h0004] = 8'h44; mem[14'h0005] = 8'h5A; mem[14'h0006] = 8'h99;

        v[0]  = mk(CW, 8'h34, 14'h0000);
        v[1]  = mk(CW, 8'h81, 14'h0000); v[1].rwe = 1; v[1].raddr = 4'h1; v[1].rdata = 8'h34;
        v[2]  = mk(CW, 8'h00, 14'h0000);
        v[3]  = mk(CW, 8'h7F, 14'h0000);
        v[4]  = mk(DW, 8'hAA, 14'h3F00); v[4].vwe = 1; v[4].vdata = 8'hAA;
        v[5]  = mk(DW, 8'hBB, 14'h3F01); v[5].vwe = 1; v[5].vdata = 8'hBB;
        v[6]  = mk(DR, 8'h00, 14'h3F02); v[6].dout = 8'hBB;
        v[7]  = mk(DR, 8'h00, 14'h3F03); v[7].dout = 8'h5C;
        v[8]  = mk(CW, 8'hFF, 14'h3F03);
        v[9]  = mk(CW, 8'h3F, 14'h3FFF); v[9].bsy = 1;
        v[10] = mk(DR, 8'h00, 14'h0000); v[10].dout = 8'h11;
        v[11] = mk(DR, 8'h00, 14'h0001); v[11].dout = 8'h22;
        v[12] = mk(CW, 8'h12, 14'h0001);
        v[13] = mk(DW, 8'h55, 14'h0012); v[13].vwe = 1; v[13].vdata = 8'h55;
        v[14] = mk(CW, 8'h05, 14'h0012);
        v[15] = mk(CW, 8'h80, 14'h0012); v[15].rwe = 1; v[15].raddr = 4'h0; v[15].rdata = 8'h05;
        v[16] = mk(CW, 8'h77, 14'h0012);
        v[17] = mk(CR, 8'h00, 14'h0012); v[17].st = 8'hA0; v[17].dout = 8'hA0;
        v[18] = mk(CW, 8'h08, 14'h0012);
        v[19] = mk(CW, 8'h82, 14'h0012); v[19].rwe = 1; v[19].raddr = 4'h2; v[19].rdata = 8'h08;
        v[20] = mk(CW, 8'h02, 14'h0012);
        v[21] = mk(CW, 8'hC0, 14'h0012);
        v[22] = mk(DW, 8'h0F, 14'h0012);
        v[23] = mk(DW, 8'h0A, 14'h0012); v[23].cwe = 1;
`ifdef VDP_GG_CRAM_EN
        v[23].caddr = 5'd1; v[23].cdata = 12'hA0F;
`else
        v[22].cwe = 1; v[22].caddr = 5'd2; v[22].cdata = 12'h00F;
        v[23].caddr = 5'd3; v[23].cdata = 12'h00A;
`endif
        v[24] = mk(DR, 8'h00, 14'h0004); v[24].dout = 8'h0A;
        v[25] = mk(DR, 8'h00, 14'h0005); v[25].dout = 8'h44;

        repeat (3) @(negedge clk);
        chk("reset_outs", -1, {cpu_dout, status_clr, vram_we, cram_we, reg_we, busy}, 0);
        chk("reset_vaddr", -1, vram_addr, 0);
        chk("reset_wdata", -1, {vram_wdata, cram_wdata, cram_addr, reg_addr, reg_data}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            status_in = v[i].st;
            strobe(v[i].kind, v[i].din);
            chk("vram_addr", i, vram_addr, v[i].vaddr);
            chk("vram_we", i, vram_we, v[i].vwe);
            if (v[i].vwe) chk("vram_wdata", i, vram_wdata, v[i].vdata);
            chk("reg_we", i, reg_we, v[i].rwe);
            if (v[i].rwe) chk("reg_addr_data", i, {reg_addr, reg_data}, {v[i].raddr, v[i].rdata});
            chk("cram_we", i, cram_we, v[i].cwe);
            if (v[i].cwe) chk("cram_addr_data", i, {cram_addr, 12'(cram_wdata)}, {v[i].caddr, v[i].cdata});
            chk("status_clr", i, status_clr, v[i].sclr);
            chk("busy", i, busy, v[i].bsy);
            if (v[i].cd) chk("cpu_dout", i, cpu_dout, v[i].dout);
            @(negedge clk);
            chk("pulse_width", i, {vram_we, cram_we, reg_we, status_clr}, 0);
            chk("busy_2nd", i, busy, v[i].bsy);
        end

        strobe(DR, 8'h00);
        chk("mid_fetch_busy", 100, busy, 1);
        chk("mid_fetch_dout", 100, cpu_dout, 8'h5A);
        chk("mid_fetch_vaddr", 100, vram_addr, 14'h0006);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 101, {busy, cpu_dout}, 0);
        chk("abort_vaddr", 101, vram_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobe(DR, 8'h00);
        chk("buf_cleared", 102, cpu_dout, 8'h00);
        chk("post_reset_vaddr", 102, vram_addr, 14'h0000);
        chk("post_reset_busy", 102, busy, 1);
        repeat (2) @(negedge clk);
        strobe(DR, 8'h00);
        chk("post_reset_fetch", 103, cpu_dout, 8'h22);
        chk("post_reset_vaddr2", 103, vram_addr, 14'h0001);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
